// File: rtl/nec_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// nec_prefetch_pkg
//   Shared types and helpers for the instruction prefetch unit.
//
//   Contents:
//     PFQ_SLOTS         number of physical prefetch-queue byte slots (always 8;
//                       the usable depth may be smaller, see nec_prefetch)
//     PHYS_W            width of a physical (segment:offset) address
//     prefetch_state_e  prefetch sequencer states
//     calc_phys_addr()  (seg << 4) + ofs, wrapping mod 2^20; also used by the
//                       execution-unit address path so both agree on wrap.
// -----------------------------------------------------------------------------
package nec_prefetch_pkg;

  localparam int PFQ_SLOTS = 8;
  localparam int PHYS_W    = 20;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_REQ     = 2'd1,
    PF_DISCARD = 2'd2
  } prefetch_state_e;

  // Segment:offset to physical address. The carry out of bit 19 is dropped,
  // so addresses above 1 MiB wrap to the bottom of memory.
  function automatic logic [PHYS_W-1:0] calc_phys_addr(input logic [15:0] seg,
                                                       input logic [15:0] ofs);
    logic [PHYS_W-1:0] seg_base;
    logic [PHYS_W-1:0] ofs_ext;
    seg_base = {seg, 4'h0};
    ofs_ext  = {4'h0, ofs};
    return seg_base + ofs_ext;
  endfunction

endpackage

// File: rtl/nec_prefetch_if.sv
// -----------------------------------------------------------------------------
// nec_prefetch_if
//   Code-fetch channel between the prefetch unit (master) and the bus unit
//   (slave).
//
//   Signals:
//     bus_req   master -> slave  fetch request, held high until bus_ack
//     bus_addr  master -> slave  20-bit physical address, stable while bus_req
//     bus_word  master -> slave  1 = 16-bit fetch (even address), 0 = byte
//     bus_ack   slave  -> master request complete, bus_data valid this edge
//     bus_data  slave  -> master even byte on [7:0], odd byte on [15:8]
// -----------------------------------------------------------------------------
interface nec_prefetch_if;
  import nec_prefetch_pkg::*;

  logic              bus_req;
  logic [PHYS_W-1:0] bus_addr;
  logic              bus_word;
  logic              bus_ack;
  logic [15:0]       bus_data;

  modport master (
    output bus_req,
    output bus_addr,
    output bus_word,
    input  bus_ack,
    input  bus_data
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    input  bus_word,
    output bus_ack,
    output bus_data
  );

endinterface

// File: rtl/nec_prefetch.sv
// -----------------------------------------------------------------------------
// nec_prefetch
//   Instruction prefetch unit: the filler side of the 8-slot instruction
//   prefetch queue consumed by the decoder. Code bytes are fetched from
//   CS:fetch_ip through the bus unit and each byte is stored at
//   ipq[address mod 8], the same indexing the decoder uses
//   (ipq[pc[2:0] + ofs]). The number of valid bytes ahead of the decoder
//   (ipq_len) is derived from the fetch pointer and the decoder's pc.
//
//   Configuration:
//     WORD_BUS            1: 16-bit bus, word fetches from even addresses
//                         0: 8-bit bus, every fetch is a byte on lane 0
//     NEC_PFQ_DEPTH6_EN   when defined, the usable queue depth is 6 bytes
//                         (V30-style); storage remains 8 slots indexed mod 8.
//                         Undefined (default): depth 8.
//
//   Ports:
//     clk        system clock
//     reset      synchronous active-high reset, honoured on every clk edge
//     ce_1/ce_2  phase clock enables; state only moves on edges with either
//                set, new requests only issue on ce_1 edges
//     cs         code segment
//     decode_pc  decoder's current pc (consumer pointer)
//     set_pc     flush/redirect strobe, new_pc is the target
//     suspend    blocks issuing new fetches (outstanding fetch still finishes)
//     bus        code-fetch channel (nec_prefetch_if.master)
//     ipq        8 x 8-bit queue storage
//     ipq_len    valid bytes starting at decode_pc, 0..DEPTH
// -----------------------------------------------------------------------------
module nec_prefetch
  import nec_prefetch_pkg::*;
#(
  parameter bit WORD_BUS = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ce_1,
  input  logic                           ce_2,
  input  logic [15:0]                    cs,
  input  logic [15:0]                    decode_pc,
  input  logic                           set_pc,
  input  logic [15:0]                    new_pc,
  input  logic                           suspend,
  nec_prefetch_if.master                 bus,
  output logic [PFQ_SLOTS-1:0][7:0]      ipq,
  output logic [3:0]                     ipq_len
);

  // Sequencer encodings, kept as plain constants so the state register is a
  // simple vector.
  localparam logic [1:0] ST_IDLE    = 2'(PF_IDLE);
  localparam logic [1:0] ST_REQ     = 2'(PF_REQ);
  localparam logic [1:0] ST_DISCARD = 2'(PF_DISCARD);

`ifdef NEC_PFQ_DEPTH6_EN
  localparam logic [3:0] DEPTH = 4'd6;
`else
  localparam logic [3:0] DEPTH = 4'd8;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]                 state_q,    state_d;
  logic                       primed_q,   primed_d;
  logic [15:0]                fetch_ip_q, fetch_ip_d;
  logic                       req_q,      req_d;
  logic [PHYS_W-1:0]          addr_q,     addr_d;
  logic                       word_q,     word_d;
  logic [PFQ_SLOTS-1:0][7:0]  ipq_q,      ipq_d;

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  logic        adv;
  logic [15:0] diff;
  logic [3:0]  len_raw;
  logic [3:0]  free;
  logic        can_word;
  logic        can_byte;
  logic        may_issue;
  logic [2:0]  slot_lo;
  logic [2:0]  slot_hi;

  // Byte lane for a single-byte fetch. On a 16-bit bus the odd byte of the
  // addressed word arrives on the high lane; an 8-bit bus always uses lane 0.
  function automatic logic [7:0] pick_byte(input logic [15:0] data,
                                           input logic        odd);
    if (WORD_BUS && odd) begin
      return data[15:8];
    end
    return data[7:0];
  endfunction

  assign adv = ce_1 | ce_2;

  // The fetch pointer runs ahead of decode_pc by at most DEPTH, so the modular
  // difference is the fill level. Any larger difference (e.g. decode_pc not
  // yet caught up after a redirect) is clamped to a full queue, which also
  // keeps the fetcher from overwriting bytes the decoder may still read.
  assign diff    = fetch_ip_q - decode_pc;
  assign len_raw = (diff >= {12'd0, DEPTH}) ? DEPTH : diff[3:0];

  // Nothing is valid before the first redirect, nor while the data of a
  // flushed request is still on its way.
  always_comb begin
    ipq_len = len_raw;
    if (!primed_q || (state_q == ST_DISCARD)) begin
      ipq_len = 4'd0;
    end
  end

  assign free = DEPTH - ipq_len;

  // Word fetches only from even addresses, so a word never straddles the
  // 0xFFFF/0x0000 segment wrap; an odd pointer first realigns with a byte.
  assign can_word  = WORD_BUS && !fetch_ip_q[0] && (free >= 4'd2);
  assign can_byte  = (!WORD_BUS || fetch_ip_q[0]) && (free >= 4'd1);
  assign may_issue = ce_1 && primed_q && !suspend && !set_pc &&
                     (can_word || can_byte);

  assign slot_lo = fetch_ip_q[2:0];
  assign slot_hi = fetch_ip_q[2:0] + 3'd1;

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    primed_d   = primed_q;
    fetch_ip_d = fetch_ip_q;
    req_d      = req_q;
    addr_d     = addr_q;
    word_d     = word_q;
    ipq_d      = ipq_q;

    if (adv) begin
      // A redirect always retargets the fetch pointer, whatever the state.
      if (set_pc) begin
        fetch_ip_d = new_pc;
        primed_d   = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (may_issue) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = calc_phys_addr(cs, fetch_ip_q);
            word_d  = can_word;
          end
        end

        ST_REQ: begin
          if (bus.bus_ack) begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
            // Data arriving on the same edge as a redirect belongs to the old
            // stream and is dropped.
            if (!set_pc) begin
              if (word_q) begin
                ipq_d[slot_lo] = bus.bus_data[7:0];
                ipq_d[slot_hi] = bus.bus_data[15:8];
                fetch_ip_d     = fetch_ip_q + 16'd2;
              end else begin
                ipq_d[slot_lo] = pick_byte(bus.bus_data, fetch_ip_q[0]);
                fetch_ip_d     = fetch_ip_q + 16'd1;
              end
            end
          end else if (set_pc) begin
            // The bus unit cannot withdraw a request, so keep it asserted
            // and swallow its data when it eventually completes.
            state_d = ST_DISCARD;
          end
        end

        ST_DISCARD: begin
          if (bus.bus_ack) begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      primed_q   <= 1'b0;
      fetch_ip_q <= 16'h0000;
      req_q      <= 1'b0;
      addr_q     <= '0;
      word_q     <= 1'b0;
      ipq_q      <= '0;
    end else begin
      state_q    <= state_d;
      primed_q   <= primed_d;
      fetch_ip_q <= fetch_ip_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      ipq_q      <= ipq_d;
    end
  end

  assign bus.bus_req  = req_q;
  assign bus.bus_addr = addr_q;
  assign bus.bus_word = word_q;
  assign ipq          = ipq_q;

endmodule

// File: tb/tb_nec_prefetch.sv
// -----------------------------------------------------------------------------
// tb_nec_prefetch
//   Directed bench for nec_prefetch (WORD_BUS=1). Expected fetch requests are
//   queued as each step is set up and compared when the DUT raises bus_req;
//   a shadow copy of the queue storage tracks what each accepted fetch
//   should have written.
// -----------------------------------------------------------------------------
module tb_nec_prefetch;
  import nec_prefetch_pkg::*;

`ifdef NEC_PFQ_DEPTH6_EN
  localparam int DEPTH = 6;
`else
  localparam int DEPTH = 8;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_1;
  logic        ce_2;
  logic [15:0] cs;
  logic [15:0] decode_pc;
  logic        set_pc;
  logic [15:0] new_pc;
  logic        suspend;
  logic [PFQ_SLOTS-1:0][7:0] ipq;
  logic [3:0]  ipq_len;

  nec_prefetch_if bus_if ();

  nec_prefetch #(.WORD_BUS(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce_1      (ce_1),
    .ce_2      (ce_2),
    .cs        (cs),
    .decode_pc (decode_pc),
    .set_pc    (set_pc),
    .new_pc    (new_pc),
    .suspend   (suspend),
    .bus       (bus_if),
    .ipq       (ipq),
    .ipq_len   (ipq_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] addr;
    logic        word;
  } req_t;

  req_t        exp_q[$];
  logic [7:0]  exp_ipq [8];
  logic [19:0] cur_addr;
  logic        cur_word;
  int          tests = 0;
  int          fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bv(input logic [15:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  function automatic logic [15:0] fdata(input logic [15:0] a);
    return {bv(a + 16'd1), bv(a)};
  endfunction

  task automatic push_req(input logic [19:0] a, input logic w);
    req_t r;
    r.addr = a;
    r.word = w;
    exp_q.push_back(r);
  endtask

  // Wait (bounded) for bus_req, then compare it against the oldest expected one.
  task automatic expect_req(input string tag);
    req_t r;
    int   n = 0;
    while (bus_if.bus_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(bus_if.bus_req), 32'd1);
    tests++;
    assert (exp_q.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb: observed empty scoreboard required pending entry", tag);
    end
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      cur_addr = r.addr;
      cur_word = r.word;
      check({tag, "_addr"}, 32'(bus_if.bus_addr), 32'(r.addr));
      check({tag, "_word"}, 32'(bus_if.bus_word), 32'(r.word));
    end
  endtask

  // Complete the current request; when write is set, model the queue update.
  task automatic do_ack(input logic [15:0] d, input bit write, input string tag);
    logic [2:0] s;
    s = cur_addr[2:0];
    bus_if.bus_ack  = 1'b1;
    bus_if.bus_data = d;
    tick();
    bus_if.bus_ack  = 1'b0;
    bus_if.bus_data = 16'h0000;
    if (write) begin
      if (cur_word) begin
        exp_ipq[s]        = d[7:0];
        exp_ipq[s + 3'd1] = d[15:8];
        check({tag, "_lo"}, 32'(ipq[s]), 32'(exp_ipq[s]));
        check({tag, "_hi"}, 32'(ipq[s + 3'd1]), 32'(exp_ipq[s + 3'd1]));
      end else begin
        exp_ipq[s] = cur_addr[0] ? d[15:8] : d[7:0];
        check({tag, "_byte"}, 32'(ipq[s]), 32'(exp_ipq[s]));
      end
    end
    check({tag, "_req_drop"}, 32'(bus_if.bus_req), 32'd0);
  endtask

  task automatic serve(input logic [19:0] a, input logic w, input string tag);
    push_req(a, w);
    expect_req(tag);
    do_ack(fdata(a[15:0]), 1'b1, tag);
  endtask

  task automatic quiet(input int n, input string tag);
    int seen = 0;
    repeat (n) begin
      tick();
      if (bus_if.bus_req !== 1'b0) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_ipq[i] = 8'h00;
    reset = 1'b1; ce_1 = 1'b1; ce_2 = 1'b0; cs = 16'h0000; decode_pc = 16'h0000;
    set_pc = 1'b0; new_pc = 16'h0000; suspend = 1'b0;
    bus_if.bus_ack = 1'b0; bus_if.bus_data = 16'h0000;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_req",  32'(bus_if.bus_req),  32'd0);
    check("rst_addr", 32'(bus_if.bus_addr), 32'd0);
    check("rst_word", 32'(bus_if.bus_word), 32'd0);
    check("rst_len",  32'(ipq_len),         32'd0);
    for (int i = 0; i < 8; i++) check("rst_ipq", 32'(ipq[i]), 32'd0);
    quiet(4, "unprimed_idle");

    // First redirect, first word fetch.
    cs = 16'hF000; decode_pc = 16'h0100; set_pc = 1'b1; new_pc = 16'h0100;
    tick();
    set_pc = 1'b0;
    push_req(20'hF0100, 1'b1);
    expect_req("first");
    do_ack(16'hBBAA, 1'b1, "first");
    check("first_ipq0", 32'(ipq[0]), 32'hAA);
    check("first_ipq1", 32'(ipq[1]), 32'hBB);
    check("first_len",  32'(ipq_len), 32'd2);

    // Fill until full, then stall.
    for (int a = 'h102; a < 'h100 + DEPTH; a += 2) serve(20'hF0000 + 20'(a), 1'b1, "fill");
    check("full_len", 32'(ipq_len), 32'(DEPTH));
    quiet(6, "full_stall");

    // Decoder consumes two bytes -> room for one more word.
    decode_pc = 16'h0102;
    serve(20'hF0100 + 20'(DEPTH), 1'b1, "refill");
    check("refill_len", 32'(ipq_len), 32'(DEPTH));

    // Odd redirect: byte first, then word.
    decode_pc = 16'h0003; set_pc = 1'b1; new_pc = 16'h0003;
    tick();
    set_pc = 1'b0;
    push_req(20'hF0003, 1'b0);
    expect_req("odd");
    do_ack(16'h5500, 1'b1, "odd");
    check("odd_ipq3", 32'(ipq[3]), 32'h55);
    check("odd_len",  32'(ipq_len), 32'd1);
    serve(20'hF0004, 1'b1, "realign");
    check("realign_len", 32'(ipq_len), 32'd3);

    // Redirect while a request is outstanding.
    push_req(20'hF0006, 1'b1);
    expect_req("inflight");
    set_pc = 1'b1; new_pc = 16'h2000; decode_pc = 16'h2000;
    tick();
    set_pc = 1'b0;
    check("discard_req_held",  32'(bus_if.bus_req),  32'd1);
    check("discard_addr_held", 32'(bus_if.bus_addr), 32'hF0006);
    check("discard_len",       32'(ipq_len),         32'd0);
    do_ack(16'hDEAD, 1'b0, "discard");
    check("discard_ipq6", 32'(ipq[6]), 32'(exp_ipq[6]));
    check("discard_ipq7", 32'(ipq[7]), 32'(exp_ipq[7]));
    check("discard_len2", 32'(ipq_len), 32'd0);

    // Redirect on the same edge as the ack.
    push_req(20'hF2000, 1'b1);
    expect_req("after_discard");
    bus_if.bus_ack = 1'b1; bus_if.bus_data = 16'h1234;
    set_pc = 1'b1; new_pc = 16'h3000; decode_pc = 16'h3000;
    tick();
    bus_if.bus_ack = 1'b0; bus_if.bus_data = 16'h0000; set_pc = 1'b0;
    check("same_edge_req",  32'(bus_if.bus_req), 32'd0);
    check("same_edge_ipq0", 32'(ipq[0]), 32'(exp_ipq[0]));
    check("same_edge_ipq1", 32'(ipq[1]), 32'(exp_ipq[1]));
    check("same_edge_len",  32'(ipq_len), 32'd0);
    serve(20'hF3000, 1'b1, "new_stream");
    check("new_stream_len", 32'(ipq_len), 32'd2);

    // suspend while a request is outstanding: it still completes.
    push_req(20'hF3002, 1'b1);
    expect_req("susp");
    suspend = 1'b1;
    tick(); tick();
    check("susp_req_held", 32'(bus_if.bus_req), 32'd1);
    do_ack(fdata(16'h3002), 1'b1, "susp");
    check("susp_len", 32'(ipq_len), 32'd4);
    quiet(5, "susp_no_issue");

    // Segment wrap of the fetch pointer.
    set_pc = 1'b1; new_pc = 16'hFFFE; decode_pc = 16'hFFFE;
    tick();
    set_pc = 1'b0;
    check("wrap_len0", 32'(ipq_len), 32'd0);
    quiet(2, "wrap_susp");
    suspend = 1'b0;
    serve(20'hFFFFE, 1'b1, "wrap_hi");
    check("wrap_len2", 32'(ipq_len), 32'd2);
    serve(20'hF0000, 1'b1, "wrap_lo");
    check("wrap_len4", 32'(ipq_len), 32'd4);

    // Clock enables: no movement without enables, no issue on ce_2 alone.
    ce_1 = 1'b0;
    quiet(4, "no_ce");
    ce_2 = 1'b1;
    quiet(3, "ce2_no_issue");
    ce_1 = 1'b1; ce_2 = 1'b0;
    push_req(20'hF0002, 1'b1);
    expect_req("ce1_issue");
    ce_1 = 1'b0;
    bus_if.bus_ack = 1'b1; bus_if.bus_data = 16'h0000;
    tick();
    bus_if.bus_ack = 1'b0;
    check("ack_gated", 32'(bus_if.bus_req), 32'd1);
    ce_2 = 1'b1;
    do_ack(fdata(16'h0002), 1'b1, "ack_ce2");
    suspend = 1'b1; ce_1 = 1'b1; ce_2 = 1'b0;
    check("ack_ce2_len", 32'(ipq_len), 32'd6);

    // Physical address wraps past 1 MiB.
    cs = 16'hFFFF; set_pc = 1'b1; new_pc = 16'h0010; decode_pc = 16'h0010;
    tick();
    set_pc = 1'b0; suspend = 1'b0;
    push_req(20'h00000, 1'b1);
    expect_req("addr_wrap");

    // Reset with a request outstanding.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_req", 32'(bus_if.bus_req), 32'd0);
    check("mid_rst_len", 32'(ipq_len), 32'd0);
    for (int i = 0; i < 8; i++) check("mid_rst_ipq", 32'(ipq[i]), 32'd0);
    quiet(4, "post_rst_unprimed");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
